// File: rtl/uart_tx_arbiter_if.sv
// Requester-side handshake bundle for uart_tx_arbiter: two valid/ready byte channels.
interface uart_tx_arbiter_if #(
  parameter int DATA_W = 8
);
  logic              req0_valid;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one 8N1 UART transmitter and baud divider between two byte requesters.
// Each bit lasts (modulus+1) clocks; the modulus is picked from sel when a byte is accepted.
module uart_tx_arbiter #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       sel,
  uart_tx_arbiter_if.slave req,
  output logic             txd,
  output logic             busy,
  output logic             owner,
  output logic             frame_done
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] IDX_LAST = {IDX_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t            state_r;
  logic [DATA_W-1:0] shift_r;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  mod_r;
  logic [IDX_W-1:0]  bit_idx_r;
  logic              last_grant_r;
  logic              bound_s;
  logic              grant0_s;
  logic              grant1_s;

  function automatic logic [CNT_W-1:0] baud_mod(input logic [1:0] s);
    case (s)
      2'b00:   baud_mod = 12'd1303;
      2'b01:   baud_mod = 12'd325;
      2'b10:   baud_mod = 12'd162;
      2'b11:   baud_mod = 12'd64;
      default: baud_mod = 12'd64;
    endcase
  endfunction

  assign bound_s        = (count_r == mod_r);
  assign req.req0_ready = grant0_s;
  assign req.req1_ready = grant1_s;

  // Idle-only arbitration; reset masks the grants so "ready" always means "taken".
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (state_r == ST_IDLE && !reset) begin
      if (req.req0_valid && req.req1_valid) begin
        grant0_s = last_grant_r;
        grant1_s = !last_grant_r;
      end else begin
        grant0_s = req.req0_valid;
        grant1_s = req.req1_valid;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Frame sequencer: accept, baud counting, bit shifting and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      shift_r      <= '0;
      count_r      <= '0;
      mod_r        <= '0;
      bit_idx_r    <= '0;
      last_grant_r <= 1'b1;
      txd          <= 1'b1;
      busy         <= 1'b0;
      owner        <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          count_r <= '0;
          if (grant0_s || grant1_s) begin
            shift_r      <= grant1_s ? req.req1_data : req.req0_data;
            mod_r        <= baud_mod(sel);
            owner        <= grant1_s;
            last_grant_r <= grant1_s;
            busy         <= 1'b1;
            txd          <= 1'b0;
            state_r      <= ST_START;
          end else begin
            busy <= 1'b0;
            txd  <= 1'b1;
          end
        end
        ST_START: begin
          count_r <= bound_s ? '0 : count_r + CNT_ONE;
          if (bound_s) begin
            txd       <= shift_r[0];
            shift_r   <= {1'b0, shift_r[DATA_W-1:1]};
            bit_idx_r <= '0;
            state_r   <= ST_DATA;
          end
        end
        ST_DATA: begin
          count_r <= bound_s ? '0 : count_r + CNT_ONE;
          if (bound_s) begin
            if (bit_idx_r == IDX_LAST) begin
              txd     <= 1'b1;
              state_r <= ST_STOP;
            end else begin
              txd       <= shift_r[0];
              shift_r   <= {1'b0, shift_r[DATA_W-1:1]};
              bit_idx_r <= bit_idx_r + IDX_ONE;
            end
          end
        end
        ST_STOP: begin
          count_r <= bound_s ? '0 : count_r + CNT_ONE;
          // Registered pulse, so it is raised one count early to land on count==modulus.
          frame_done <= (count_r == mod_r - CNT_ONE);
          if (bound_s) begin
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          txd     <= 1'b1;
          busy    <= 1'b0;
          count_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: drivers queue expected frames, a line monitor decodes txd.
module tb_uart_tx_arbiter;

  typedef struct {
    bit         ch;
    logic [7:0] data;
    int         per;
    bit         b2b;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [1:0] sel;
  logic       txd;
  logic       busy;
  logic       owner;
  logic       frame_done;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   idle_cnt = 1000;
  bit   mon_active = 1'b0;

  uart_tx_arbiter_if #(.DATA_W(8)) bus ();

  uart_tx_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .sel        (sel),
    .req        (bus),
    .txd        (txd),
    .busy       (busy),
    .owner      (owner),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name, input int act, input int expv);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic push(input bit ch, input logic [7:0] data, input int per, input bit b2b);
    exp_t e;
    e.ch = ch; e.data = data; e.per = per; e.b2b = b2b;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold valids until each is granted, dropping a valid right after its accept edge.
  task automatic serve(input int budget);
    int n;
    logic r0, r1;
    n = 0;
    while ((bus.req0_valid || bus.req1_valid) && n < budget) begin
      @(negedge clk);
      r0 = bus.req0_ready;
      r1 = bus.req1_ready;
      @(posedge clk); #1;
      if (r0) bus.req0_valid = 1'b0;
      if (r1) bus.req1_valid = 1'b0;
      n++;
    end
    check(!(bus.req0_valid || bus.req1_valid), "serve_timeout", n, budget);
  endtask

  task automatic wait_quiet(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(exp_q.size() == 0 && !mon_active && !busy) && n < budget);
    check(exp_q.size() == 0 && !mon_active && !busy, "quiet_timeout", n, budget);
    @(posedge clk); #1;
  endtask

  // Line monitor: every cycle of every bit is compared against the expected frame.
  initial begin : monitor
    exp_t       e;
    logic [9:0] bits;
    int         bad, fd_bad, bs_bad;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (reset) begin
        idle_cnt = 1000;
      end else if (txd === 1'b0) begin
        mon_active = 1'b1;
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_frame", 1, 0);
          for (int w = 0; w < 20000 && busy; w++) @(negedge clk);
          idle_cnt = 1000;
        end else begin
          e = exp_q.pop_front();
          if (e.b2b) check(idle_cnt == 0, "b2b_gap", idle_cnt, 0);
          check(owner === e.ch, "owner", owner, e.ch);
          bits    = {1'b1, e.data, 1'b0};
          aborted = 1'b0;
          fd_bad  = 0;
          bs_bad  = 0;
          for (int b = 0; b < 10 && !aborted; b++) begin
            bad = 0;
            for (int c = 0; c < e.per && !aborted; c++) begin
              if (b != 0 || c != 0) @(negedge clk);
              if (reset) begin
                aborted = 1'b1;
              end else begin
                if (txd !== bits[b]) bad++;
                if (frame_done !== (b == 9 && c == e.per - 1)) fd_bad++;
                if (busy !== 1'b1) bs_bad++;
              end
            end
            if (!aborted) check(bad == 0, $sformatf("frame_bit%0d_data%02h", b, e.data), bad, 0);
          end
          if (!aborted) begin
            check(fd_bad == 0, "frame_done_timing", fd_bad, 0);
            check(bs_bad == 0, "busy_in_frame", bs_bad, 0);
            @(negedge clk);
            if (!reset) check(busy === 1'b0, "busy_after_frame", busy, 0);
            idle_cnt = 0;
          end else begin
            idle_cnt = 1000;
          end
        end
        mon_active = 1'b0;
      end else begin
        idle_cnt++;
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [7:0] bytes [3];
    int         r0_bad;
    bit         got;

    reset = 1'b1;
    sel   = 2'b00;
    bus.req0_valid = 1'b0; bus.req0_data = 8'h00;
    bus.req1_valid = 1'b0; bus.req1_data = 8'h00;
    step(3);

    // Reset state
    @(negedge clk);
    check(txd === 1'b1, "rst_txd", txd, 1);
    check(busy === 1'b0, "rst_busy", busy, 0);
    check(owner === 1'b0, "rst_owner", owner, 0);
    check(frame_done === 1'b0, "rst_frame_done", frame_done, 0);
    @(posedge clk); #1;

    // Single frame 0xA5 at the fastest rate
    reset = 1'b0;
    sel   = 2'b11;
    bus.req0_data  = 8'hA5;
    bus.req0_valid = 1'b1;
    push(1'b0, 8'hA5, 65, 1'b0);
    @(negedge clk);
    check(bus.req0_ready === 1'b1, "t1_ready", bus.req0_ready, 1);
    check(bus.req1_ready === 1'b0, "t1_ready1", bus.req1_ready, 0);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    @(negedge clk);
    check(bus.req0_ready === 1'b0, "t1_ready_pulse", bus.req0_ready, 0);
    check(busy === 1'b1, "t1_busy", busy, 1);
    wait_quiet(2000);

    // Contention from reset: ch0 first, ch1 back-to-back, then ch0 again
    reset = 1'b1;
    sel   = 2'b10;
    bus.req0_data = 8'h3C; bus.req0_valid = 1'b1;
    bus.req1_data = 8'hC3; bus.req1_valid = 1'b1;
    push(1'b0, 8'h3C, 163, 1'b0);
    push(1'b1, 8'hC3, 163, 1'b1);
    step(2);
    reset = 1'b0;
    serve(4000);
    bus.req0_data = 8'h01; bus.req0_valid = 1'b1;
    bus.req1_data = 8'h80; bus.req1_valid = 1'b1;
    push(1'b0, 8'h01, 163, 1'b1);
    push(1'b1, 8'h80, 163, 1'b1);
    serve(6000);
    wait_quiet(4000);

    // sel changed mid-frame only affects the next frame
    sel = 2'b00;
    bus.req0_data = 8'h5A; bus.req0_valid = 1'b1;
    push(1'b0, 8'h5A, 1304, 1'b0);
    serve(10);
    step(100);
    sel = 2'b01;
    wait_quiet(20000);
    bus.req0_data = 8'h96; bus.req0_valid = 1'b1;
    push(1'b0, 8'h96, 326, 1'b0);
    serve(10);
    wait_quiet(5000);

    // Reset during data bit 3 abandons the frame; IDLE arbitration resumes at once
    sel = 2'b11;
    bus.req1_data = 8'hF0; bus.req1_valid = 1'b1;
    push(1'b1, 8'hF0, 65, 1'b0);
    serve(10);
    step(65 * 4 + 20);
    reset = 1'b1;
    bus.req0_data = 8'h3A; bus.req0_valid = 1'b1;
    bus.req1_data = 8'h55; bus.req1_valid = 1'b1;
    push(1'b0, 8'h3A, 65, 1'b0);
    push(1'b1, 8'h55, 65, 1'b1);
    step(1);
    reset = 1'b0;
    @(negedge clk);
    check(txd === 1'b1, "t4_txd_after_rst", txd, 1);
    check(busy === 1'b0, "t4_busy_after_rst", busy, 0);
    check(bus.req0_ready === 1'b1, "t4_ready0", bus.req0_ready, 1);
    check(bus.req1_ready === 1'b0, "t4_ready1", bus.req1_ready, 0);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    serve(2000);
    wait_quiet(2000);

    // Only ch1 streaming; its data toggles mid-frame; a stray ch0 pulse while busy
    bytes = '{8'h11, 8'h6E, 8'hC9};
    bus.req1_data  = bytes[0];
    bus.req1_valid = 1'b1;
    push(1'b1, bytes[0], 65, 1'b0);
    for (int k = 0; k < 3; k++) begin
      got    = 1'b0;
      r0_bad = 0;
      for (int c = 0; c < 2000 && !got; c++) begin
        @(negedge clk);
        if (bus.req0_ready !== 1'b0) r0_bad++;
        got = bus.req1_ready;
      end
      check(got, "t5_grant", got, 1);
      check(r0_bad == 0, "t5_ready0_low", r0_bad, 0);
      @(posedge clk); #1;
      if (k < 2) begin
        bus.req1_data = ~bytes[k];
        push(1'b1, bytes[k + 1], 65, 1'b1);
        step(200);
        bus.req1_data = bytes[k + 1];
      end else begin
        bus.req1_valid = 1'b0;
        bus.req1_data  = 8'hFF;
      end
    end
    step(100);
    bus.req0_data  = 8'h42;
    bus.req0_valid = 1'b1;
    @(negedge clk);
    check(bus.req0_ready === 1'b0, "t6_no_ready_busy", bus.req0_ready, 0);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    wait_quiet(2000);
    step(50);
    @(negedge clk);
    check(txd === 1'b1, "t6_txd_idle", txd, 1);
    check(busy === 1'b0, "t6_no_frame", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one 8N1 UART transmitter and its baud divider between two byte-stream requesters.
- Round-robin arbitration; the winner's byte is framed (start, 8 data LSB-first, stop) and shifted out at the rate selected by sel.
- Baud modulus table matches the team's existing divider: sel 00/01/10/11 -> 1303/325/162/64. Bit period = modulus+1 clocks.
- Sits between on-chip producers (command/response paths) and the txd pin.

Parameters:
- DATA_W, 8, payload bits per frame; fixed at 8 for this revision.
- CNT_W, 12, baud counter width; must hold 1303.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- sel  input  2  baud select; sampled only at frame accept.
- req0_valid  input  1  requester 0 has a byte.
- req0_data  input  8  requester 0 byte.
- req0_ready  output  1  requester 0 byte accepted this cycle (valid&ready).
- req1_valid  input  1  requester 1 has a byte.
- req1_data  input  8  requester 1 byte.
- req1_ready  output  1  requester 1 byte accepted this cycle.
- txd  output  1  serial line, idle high.
- busy  output  1  frame in progress.
- owner  output  1  index of the requester whose frame is in progress / last sent.
- frame_done  output  1  one-cycle pulse in the last clock of the stop bit.

Behaviour:
- Reset (clk edge with reset=1) overrides everything, including a frame in progress: state=IDLE, txd=1, busy=0, owner=0, frame_done=0, baud count=0, last_grant=1 (so ch0 wins first contention). A frame cut by reset is abandoned, not resumed.
- States: IDLE, START, DATA, STOP.
- IDLE, req ready logic (combinational, no registers):
  - Only one valid asserted -> that channel's ready=1.
  - Both valid -> grant the channel != last_grant.
  - Outside IDLE both readies are 0.
  - Valid must not depend on ready.
- Accept edge (valid&ready):
  - Latch data into the shift register and latch modulus from sel.
  - owner<=winner, last_grant<=winner, count<=0, busy<=1, state<=START.
  - txd goes 0 on the same edge, so txd is low in cycle N+1 after accept in cycle N.
- Baud counter: increments each clock while busy. When count==latched modulus, count<=0 and a bit boundary occurs. Each bit is therefore exactly modulus+1 clocks.
- START: at boundary -> DATA, txd<=data[0], bit index=0.
- DATA: at each boundary, shift out the next bit LSB-first. After bit 7's boundary -> STOP, txd<=1.
- STOP: frame_done=1 in the cycle where count==modulus. At that boundary -> IDLE, busy<=0, txd stays 1.
- Frame length: 10*(modulus+1) clocks from the first low txd cycle to the first IDLE cycle.
- Back-to-back: a new accept is possible in the first IDLE cycle, giving zero idle gap. A stop bit of exactly modulus+1 cycles is guaranteed.
- sel changes mid-frame are ignored until the next accept.
- Data-input changes after accept have no effect.
- Valid dropped before acceptance: no frame is sent, no state change.
- Count is sized to CNT_W, so no wrap occurs with the table values.

Test Plan:
- Reset, then sel=11, req0_valid=1, data=0xA5 -> req0_ready pulses 1 cycle. txd=0 for 65 clocks, then bits 1,0,1,0,0,1,0,1 at 65 clocks each, then high 65 clocks. frame_done at clock 650, busy low after.
- Both valid from reset, sel=10 -> ch0 granted first (owner=0). On return to IDLE ch1 granted immediately, so the ch1 start bit begins the cycle after the ch0 stop bit ends. Next contention goes to ch0 again.
- sel=00 at accept, switched to 01 mid-frame -> every bit of the current frame lasts 1304 clocks. The next frame's bits last 326 clocks.
- Assert reset during DATA bit 3 -> next cycle txd=1, busy=0, both readies reflect IDLE arbitration. The next frame is complete and correct.
- Only req1_valid held continuously, sel=11 -> req1 granted every frame, frames contiguous, req0_ready stays 0. Toggling req1_data mid-frame does not alter transmitted bits.
- req0_valid pulsed for 1 cycle while busy -> no ready, no frame generated for it.
